serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around a single 1-bit full-adder cell.
- Each cycle the cell is fed one LSB-first bit pair plus a registered carry. Its carry-out is registered and fed back as the next carry-in.
- Trades WIDTH cycles of latency for one adder cell. Sits between operand-producing logic and any consumer of the sum, using a start/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2)

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  initial carry-in, captured on accepted start
- busy  output  1  high while serial addition in progress
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result; holds last value until next completion
- cout  output  1  final carry-out; holds with sum

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). rst sampled high at a rising edge forces:
  - state=IDLE
  - shift regs, carry reg and bit counter = 0
  - busy=0, done=0, sum=0, cout=0
- rst has priority over every other input, including mid-operation; a partial result is discarded and done is not pulsed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: load A_sh<=a, B_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - On start=0: stay.
- RUN:
  - busy=1. Each edge, the full-adder cell computes s=A_sh[0]^B_sh[0]^carry and c=majority(A_sh[0],B_sh[0],carry).
  - S_sh<={s,S_sh[WIDTH-1:1]}; A_sh, B_sh shift right by 1; carry<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (last bit), go to DONE. Also load sum<={s,S_sh[WIDTH-1:1]} and cout<=c.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no dead cycle). Otherwise go to IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 (RUN) is ignored; operands are not re-captured and no error is flagged.
- a, b and cin are don't-care except at the accepting edge.
- sum and cout change only on the completion edge (and on reset). They are stable in all other cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- cnt is $clog2(WIDTH) bits wide, sized to hold values up to WIDTH-1. It does not wrap within an operation.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), the two's-complement overflow flag.
  - ovf = (carry into the MSB) XOR (carry out of the MSB). The carry into the MSB is the carry register value while cnt==WIDTH-1.
  - ovf is registered on the completion edge alongside sum/cout, and holds until the next completion.
  - Reset value 0.
- Not defined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan (WIDTH=8):
- Reset 2 cycles, then idle 3 cycles → busy=0, done=0, sum=0x00, cout=0 throughout.
- a=0x3C, b=0x5A, cin=0, start pulse at edge k → busy high edges k+1..k+8; done high for one cycle after edge k+8; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start accepted, then at cycle 3 drive start=1 with a=0x11, b=0x22 → ignored; the original operands complete. Re-issue start in the DONE cycle → second result follows with no idle cycle between operations.
- Assert rst at cycle 4 of RUN → next cycle busy=0, sum=0, no done pulse. A new start afterwards computes correctly.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 → sum=0x80, ovf=1. 0x80+0x80 → sum=0x00, cout=1, ovf=1. 0x10+0x20 → ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, with a start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   // Holds the WIDTH-1 low sum bits already produced; the final bit comes straight from the cell.
   logic [WIDTH-2:0]   s_sh_q, s_sh_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               s_bit_s;
   logic               c_bit_s;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   assign s_bit_s = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
   assign c_bit_s = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);

   // Next-state, datapath and handshake decode
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = {CNT_W{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            s_sh_d  = (WIDTH-1)'({s_bit_s, s_sh_q} >> 1);
            carry_d = c_bit_s;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = {CNT_W{1'b0}};
               sum_d   = {s_bit_s, s_sh_q};
               cout_d  = c_bit_s;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB on this last step
               ovf_d   = carry_q ^ c_bit_s;
`endif
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= {WIDTH{1'b0}};
         b_sh_q  <= {WIDTH{1'b0}};
         s_sh_q  <= {(WIDTH-1){1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
